// File: rtl/sha256_mem_1r1w_fifo_ctrl.sv
// FIFO controller driving an external 1r1w RAM (async read), ready/valid in, valid/yumi out.
// Optional occupancy counter enabled by defining SHA256_FIFO_COUNT_EN.
module sha256_mem_1r1w_fifo_ctrl #(
   parameter int width_p        = 32,
   parameter int els_p          = 16,
   parameter int addr_width_lp  = (els_p > 1) ? $clog2(els_p) : 1,
   parameter int count_width_lp = (els_p + 1 > 1) ? $clog2(els_p + 1) : 1
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      v_i,
   input  logic [width_p-1:0]        data_i,
   output logic                      ready_o,
   output logic                      v_o,
   output logic [width_p-1:0]        data_o,
   input  logic                      yumi_i,
   output logic [count_width_lp-1:0] count_o,
   output logic                      w_v_o,
   output logic [addr_width_lp-1:0]  w_addr_o,
   output logic [width_p-1:0]        w_data_o,
   output logic                      r_v_o,
   output logic [addr_width_lp-1:0]  r_addr_o,
   input  logic [width_p-1:0]        r_data_i
);

   localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);

   logic [addr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [addr_width_lp-1:0] wptr_inc, rptr_inc;
   logic                     full_q, full_d, empty_q, empty_d;
   logic                     enq, deq;

   // Reset gating keeps the RAM write port quiet while reset is held.
   always_comb begin
      enq      = v_i & ~full_q & reset_n_i;
      deq      = yumi_i & ~empty_q;
      wptr_inc = (wptr_q == last_lp) ? '0 : wptr_q + addr_width_lp'(1);
      rptr_inc = (rptr_q == last_lp) ? '0 : rptr_q + addr_width_lp'(1);
   end

   always_comb begin
      wptr_d  = enq ? wptr_inc : wptr_q;
      rptr_d  = deq ? rptr_inc : rptr_q;
      full_d  = full_q;
      empty_d = empty_q;
      if (enq && !deq) begin
         empty_d = 1'b0;
         full_d  = (wptr_inc == rptr_q);
      end else if (deq && !enq) begin
         full_d  = 1'b0;
         empty_d = (rptr_inc == wptr_q);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_comb begin
      ready_o  = ~full_q;
      v_o      = ~empty_q;
      w_v_o    = enq;
      w_addr_o = wptr_q;
      w_data_o = data_i;
      r_v_o    = ~empty_q;
      r_addr_o = rptr_q;
      data_o   = r_data_i;
   end

`ifdef SHA256_FIFO_COUNT_EN
   logic [count_width_lp-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (enq && !deq)      count_d = count_q + count_width_lp'(1);
      else if (deq && !enq) count_d = count_q - count_width_lp'(1);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) count_q <= '0;
      else            count_q <= count_d;
   end

   assign count_o = count_q;
`else
   assign count_o = '0;
`endif

`ifndef SYNTHESIS
   // A yumi with nothing to dequeue is a consumer bug; the RTL ignores it.
   always @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(yumi_i && empty_q))
            else $error("yumi_i asserted while FIFO empty");
      end
   end
`endif

endmodule

// File: tb/tb_sha256_mem_1r1w_fifo_ctrl.sv
// Bench for sha256_mem_1r1w_fifo_ctrl: depth-4 and depth-5 instances with inline 1r1w RAMs,
// checked every cycle against queue-based reference models.
module tb_sha256_mem_1r1w_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v_i = 1'b0;
   logic [7:0] data_i = 8'h00;
   logic       yumi4 = 1'b0, yumi5 = 1'b0;
   logic       chk_en = 1'b0;

   logic       rdy4, vo4, wv4, rv4;
   logic [7:0] do4, wd4, rd4;
   logic [2:0] cnt4;
   logic [1:0] wa4, ra4;

   logic       rdy5, vo5, wv5, rv5;
   logic [7:0] do5, wd5, rd5;
   logic [2:0] cnt5;
   logic [2:0] wa5, ra5;

   int errors = 0;
   int checks = 0;

   logic [7:0] q4[$];
   logic [7:0] q5[$];
   int wc4 = 0, rc4 = 0, wc5 = 0, rc5 = 0;

   always #5 clk = ~clk;

   sha256_mem_1r1w_fifo_ctrl #(.width_p(8), .els_p(4)) dut4 (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .ready_o(rdy4),
      .v_o(vo4), .data_o(do4), .yumi_i(yumi4), .count_o(cnt4), .w_v_o(wv4),
      .w_addr_o(wa4), .w_data_o(wd4), .r_v_o(rv4), .r_addr_o(ra4), .r_data_i(rd4));

   sha256_mem_1r1w_fifo_ctrl #(.width_p(8), .els_p(5)) dut5 (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .data_i(data_i), .ready_o(rdy5),
      .v_o(vo5), .data_o(do5), .yumi_i(yumi5), .count_o(cnt5), .w_v_o(wv5),
      .w_addr_o(wa5), .w_data_o(wd5), .r_v_o(rv5), .r_addr_o(ra5), .r_data_i(rd5));

   // 1r1w RAMs: synchronous write, asynchronous read
   logic [7:0] mem4 [4];
   logic [7:0] mem5 [5];
   always @(posedge clk) if (wv4) mem4[wa4] <= wd4;
   always @(posedge clk) if (wv5 && wa5 < 3'd5) mem5[wa5] <= wd5;
   assign rd4 = mem4[ra4];
   assign rd5 = (ra5 < 3'd5) ? mem5[ra5] : 8'hxx;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO is a queue; addresses are transfer counts modulo depth.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q4.delete(); q5.delete();
            wc4 = 0; rc4 = 0; wc5 = 0; rc5 = 0;
         end else begin
            automatic bit e4 = v_i && q4.size() < 4;
            automatic bit d4 = yumi4 && q4.size() > 0;
            automatic bit e5 = v_i && q5.size() < 5;
            automatic bit d5 = yumi5 && q5.size() > 0;
            if (d4) begin void'(q4.pop_front()); rc4 = (rc4 + 1) % 4; end
            if (e4) begin q4.push_back(data_i);  wc4 = (wc4 + 1) % 4; end
            if (d5) begin void'(q5.pop_front()); rc5 = (rc5 + 1) % 5; end
            if (e5) begin q5.push_back(data_i);  wc5 = (wc5 + 1) % 5; end
         end
      end
   end

   function automatic int exp_cnt(input int sz);
`ifdef SHA256_FIFO_COUNT_EN
      return sz;
`else
      return 0;
`endif
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready4", rdy4, q4.size() < 4);
         chk("v_o4",   vo4,  q4.size() > 0);
         chk("r_v4",   rv4,  q4.size() > 0);
         chk("w_v4",   wv4,  rst_n && v_i && q4.size() < 4);
         chk("count4", cnt4, exp_cnt(q4.size()));
         if (wv4) begin
            chk("w_addr4", wa4, wc4);
            chk("w_data4", wd4, data_i);
         end
         if (q4.size() > 0) begin
            chk("r_addr4", ra4, rc4);
            chk("data4",   do4, q4[0]);
         end
         if (wv4 && rv4) chk("same_addr4", wa4 != ra4, 1);

         chk("ready5", rdy5, q5.size() < 5);
         chk("v_o5",   vo5,  q5.size() > 0);
         chk("r_v5",   rv5,  q5.size() > 0);
         chk("w_v5",   wv5,  rst_n && v_i && q5.size() < 5);
         chk("count5", cnt5, exp_cnt(q5.size()));
         if (wv5) chk("w_addr5", wa5, wc5);
         if (q5.size() > 0) begin
            chk("r_addr5", ra5, rc5);
            chk("data5",   do5, q5[0]);
         end
         if (wv5 && rv5) chk("same_addr5", wa5 != ra5, 1);
      end
   end

   // Inputs change 2 time units after the rising edge; yumi only when the model holds data.
   task automatic drive(input bit v, input logic [7:0] d, input bit y4, input bit y5);
      @(posedge clk);
      #2;
      v_i    = v;
      data_i = d;
      yumi4  = y4 && (q4.size() > 0);
      yumi5  = y5 && (q5.size() > 0);
   endtask

   initial begin
      logic [7:0] fill_vals [4];
      fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

      repeat (2) @(posedge clk);
      #2 chk_en = 1'b1;
      rst_n = 1'b1;
      drive(0, 8'h00, 0, 0);
      #1;
      chk("rst_ready", rdy4, 1);
      chk("rst_v_o",   vo4,  0);
      chk("rst_w_v",   wv4,  0);
      chk("rst_r_v",   rv4,  0);
      chk("rst_count", cnt4, 0);

      // Fill depth-4 instance, then offer a fifth word
      for (int i = 0; i < 4; i++) drive(1, fill_vals[i], 0, 0);
      drive(1, 8'h55, 0, 0);
      #1;
      chk("fill_ready4", rdy4, 0);
      chk("fill_5th_no_write", wv4, 0);
      chk("fill_head", do4, 8'h11);
`ifdef SHA256_FIFO_COUNT_EN
      chk("fill_count4", cnt4, 4);
`endif

      // Drain with yumi held
      for (int i = 0; i < 4; i++) begin
         drive(0, 8'h00, 1, 1);
         #1;
         chk("drain_data", do4, fill_vals[i]);
         if (i == 1) chk("drain_ready_after_first_deq", rdy4, 1);
      end
      drive(0, 8'h00, 0, 1);
      #1 chk("drain_empty4", vo4, 0);
      repeat (2) drive(0, 8'h00, 0, 1);
      drive(0, 8'h00, 0, 0);
      #1 chk("drain_empty5", vo5, 0);

      // Wrap: occupancy 2, then ten simultaneous enq+deq pairs
      drive(1, 8'hA0, 0, 0);
      drive(1, 8'hA1, 0, 0);
      for (int i = 0; i < 10; i++) drive(1, 8'(i), 1, 1);
      drive(0, 8'h00, 0, 0);
      #1;
      chk("wrap_v_o4",   vo4,  1);
      chk("wrap_ready4", rdy4, 1);
      chk("wrap_head4",  do4,  8'h08);
      chk("wrap_head5",  do5,  8'h08);
`ifdef SHA256_FIFO_COUNT_EN
      chk("wrap_count4", cnt4, 2);
`endif
      repeat (3) drive(0, 8'h00, 1, 1);

      // Random traffic
      for (int i = 0; i < 2000; i++)
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));

      // Reset mid-stream at occupancy 3
      drive(0, 8'h00, 0, 0);
      while (q4.size() > 0) drive(0, 8'h00, 1, 1);
      while (q5.size() > 0) drive(0, 8'h00, 0, 1);
      for (int i = 0; i < 3; i++) drive(1, 8'(8'h60 + i), 0, 0);
      drive(0, 8'h00, 0, 0);
      chk("pre_reset_occ4", vo4, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_v_o4",  vo4,  0);
      chk("mid_rst_v_o5",  vo5,  0);
      chk("mid_rst_count", cnt4, 0);
      chk("mid_rst_ready", rdy4, 1);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1, 8'hAA, 0, 0);
      drive(0, 8'h00, 1, 1);
      #1;
      chk("post_rst_first4", do4, 8'hAA);
      chk("post_rst_first5", do5, 8'hAA);
      drive(0, 8'h00, 0, 0);
      #1 chk("post_rst_empty4", vo4, 0);
      drive(0, 8'h00, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
